// File: rtl/imem_sync_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : imem_sync_loadable
//  Description : Run-time loadable synchronous instruction memory for the
//                LEGv8 core. A byte PC is turned into a word index and read
//                with one cycle of latency. Reads hold while the pipeline is
//                stalled. Alignment and range faults are flagged.
//                After reset, every word is cleared to DEFAULT_INSTR.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_sync_loadable #(
    parameter int          DEPTH         = 64,
    parameter int          AW            = $clog2(DEPTH),
    parameter logic [31:0] DEFAULT_INSTR = 32'hD600_0160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        rd_stall,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fault_misalign,
    output logic        fault_range,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        init_busy
);

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     rdata_q;
    logic            dflt_q;       // instr_out shows DEFAULT_INSTR instead of RAM data
    logic            valid_q;
    logic            mis_q;
    logic            rng_q;

    logic [AW-1:0]   w_rd_idx;
    logic            w_rd_oor;
    logic            w_rd_acc;
    logic            w_wr_ok;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_waddr;
    logic [31:0]     w_mem_wdata;

    // Upper address bits above the index mean the word lies beyond DEPTH.
    assign w_rd_idx = rd_addr[AW+1:2];
    assign w_rd_oor = |rd_addr[31:AW+2];
    assign w_rd_acc = (state_q == ST_RUN) && rd_req && !rd_stall && !reset;
    assign w_wr_ok  = (state_q == ST_RUN) && wr_en
                      && (wr_addr[1:0] == 2'b00) && !(|wr_addr[31:AW+2]);

    // State and clear-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk the clear counter through every word, then run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_busy = (state_q == ST_INIT);

    // One RAM write port. The clear sequence owns it during INIT.
    // The programming port owns it during RUN.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = wr_addr[AW+1:2];
        w_mem_wdata = wr_data;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = cnt_q;
                w_mem_wdata = DEFAULT_INSTR;
            end else if (w_wr_ok) begin
                w_mem_we    = 1'b1;
            end
        end
    end

    // RAM write port. The array has no reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Registered RAM read. It holds its value unless a request is accepted.
    // It reads the old word when a write hits the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            rdata_q <= mem_q[w_rd_idx];
        end
    end

    // Fetch status flags. They hold on a stall and clear on an idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dflt_q  <= 1'b1;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else if (state_q == ST_INIT) begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else if (!rd_stall) begin
            valid_q <= rd_req;
            mis_q   <= rd_req && (rd_addr[1:0] != 2'b00);
            rng_q   <= rd_req && w_rd_oor;
            if (rd_req) begin
                dflt_q <= w_rd_oor;
            end
        end
    end

    assign instr_out      = dflt_q ? DEFAULT_INSTR : rdata_q;
    assign instr_valid    = valid_q;
    assign fault_misalign = mis_q;
    assign fault_range    = rng_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_sync_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_sync_loadable
//  Description : Self-checking bench for imem_sync_loadable. It runs directed
//                scenarios, then random traffic checked against a word-array
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_sync_loadable;

    localparam int          DEPTH = 64;
    localparam logic [31:0] DEF   = 32'hD600_0160;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_stall = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fault_misalign;
    logic        fault_range;
    logic        init_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word array plus the expected output state.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_instr = DEF;
    logic        m_valid = 1'b0;
    logic        m_mis = 1'b0;
    logic        m_rng = 1'b0;
    int          m_init = DEPTH;

    imem_sync_loadable #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_stall       (rd_stall),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .fault_misalign (fault_misalign),
        .fault_range    (fault_range),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .init_busy      (init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic req, input logic stall, input logic [31:0] addr,
                         input logic we, input logic [31:0] waddr, input logic [31:0] wdata);
        rd_req   = req;
        rd_stall = stall;
        rd_addr  = addr;
        wr_en    = we;
        wr_addr  = waddr;
        wr_data  = wdata;
    endtask

    // Advance one clock. Update the model from the inputs seen at the edge.
    // Return at the falling edge, so the caller can sample outputs and drive new inputs.
    task automatic cyc();
        logic [31:0] idx;
        logic [31:0] widx;
        @(posedge clk);
        if (reset) begin
            m_init  = DEPTH;
            m_instr = DEF;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_rng   = 1'b0;
        end else if (m_init > 0) begin
            m_mem[DEPTH - m_init] = DEF;
            m_init = m_init - 1;
        end else begin
            if (!rd_stall) begin
                if (rd_req) begin
                    idx     = rd_addr >> 2;
                    m_instr = (idx < DEPTH) ? m_mem[idx[5:0]] : DEF;
                    m_valid = 1'b1;
                    m_mis   = (rd_addr % 4) != 0;
                    m_rng   = idx >= DEPTH;
                end else begin
                    m_valid = 1'b0;
                    m_mis   = 1'b0;
                    m_rng   = 1'b0;
                end
            end
            widx = wr_addr >> 2;
            if (wr_en && (wr_addr % 4) == 0 && widx < DEPTH) begin
                m_mem[widx[5:0]] = wr_data;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'hFC;
        reset = 1'b1;
        cyc(); cyc();
        n_cmp++; if (init_busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got=%b exp=1", init_busy); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (instr_out !== DEF) begin n_bad++; $display("FAIL rst_instr got=%h exp=%h", instr_out, DEF); end
        n_cmp++; if ({fault_misalign, fault_range} !== 2'b00) begin n_bad++; $display("FAIL rst_faults got=%b%b exp=00", fault_misalign, fault_range); end
        reset = 1'b0;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 200) begin
            cnt++;
            cyc();
        end
        n_cmp++; if (cnt != 64) begin n_bad++; $display("FAIL init_len got=%0d exp=64", cnt); end
        foreach (addrs[i]) begin
            drive(1'b1, 1'b0, addrs[i], 1'b0, 32'h0, 32'h0);
            cyc();
            n_cmp++; if ({instr_out, instr_valid, fault_misalign, fault_range} !== {DEF, 3'b100}) begin
                n_bad++; $display("FAIL clear_read addr=%h got=%h v%b m%b r%b exp=%h v1 m0 r0",
                                  addrs[i], instr_out, instr_valid, fault_misalign, fault_range, DEF);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc();
    endtask

    task automatic test_load_fetch();
        logic [31:0] words [3];
        words[0] = 32'hD280_0021; words[1] = 32'hD280_0042; words[2] = 32'h8B02_0024;
        foreach (words[i]) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), words[i]);
            cyc();
        end
        foreach (words[i]) begin
            drive(1'b1, 1'b0, 32'(i * 4), 1'b0, 32'h0, 32'h0);
            cyc();
            n_cmp++; if (instr_out !== words[i] || instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL fetch addr=%h got=%h v%b exp=%h v1", i * 4, instr_out, instr_valid, words[i]);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc();
        n_cmp++; if (instr_valid !== 1'b0 || instr_out !== words[2]) begin
            n_bad++; $display("FAIL idle_hold got=%h v%b exp=%h v0", instr_out, instr_valid, words[2]);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
            cyc();
            n_cmp++; if (instr_out !== 32'hD280_0042 || instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold cyc=%0d got=%h v%b exp=d2800042 v1", i, instr_out, instr_valid);
            end
        end
        drive(1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0);
        cyc();
        n_cmp++; if (instr_out !== 32'h8B02_0024 || instr_valid !== 1'b1) begin
            n_bad++; $display("FAIL stall_release got=%h v%b exp=8b020024 v1", instr_out, instr_valid);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc();
    endtask

    task automatic test_faults();
        drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        cyc();
        n_cmp++; if ({instr_out, instr_valid, fault_misalign, fault_range} !== {DEF, 3'b101}) begin
            n_bad++; $display("FAIL range got=%h v%b m%b r%b exp=%h v1 m0 r1", instr_out, instr_valid, fault_misalign, fault_range, DEF);
        end
        drive(1'b1, 1'b0, 32'h6, 1'b0, 32'h0, 32'h0);
        cyc();
        n_cmp++; if ({instr_out, instr_valid, fault_misalign, fault_range} !== {32'hD280_0042, 3'b110}) begin
            n_bad++; $display("FAIL misalign got=%h v%b m%b r%b exp=d2800042 v1 m1 r0", instr_out, instr_valid, fault_misalign, fault_range);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 32'h1111_1111); cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 32'h2222_2222); cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2,   32'h3333_3333); cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc();
        n_cmp++; if (instr_out !== 32'hD280_0021 || fault_range !== 1'b0) begin
            n_bad++; $display("FAIL bad_write_0 got=%h r%b exp=d2800021 r0", instr_out, fault_range);
        end
        drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        cyc();
        n_cmp++; if (instr_out !== DEF || fault_range !== 1'b1) begin
            n_bad++; $display("FAIL bad_write_100 got=%h r%b exp=%h r1", instr_out, fault_range, DEF);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc();
        n_cmp++; if ({instr_valid, fault_misalign, fault_range} !== 3'b000) begin
            n_bad++; $display("FAIL idle_clear got=v%b m%b r%b exp=000", instr_valid, fault_misalign, fault_range);
        end
    endtask

    task automatic test_same_word();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'hAAAA_AAAA); cyc();
        drive(1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 32'h5555_5555); cyc();
        n_cmp++; if (instr_out !== 32'hAAAA_AAAA) begin
            n_bad++; $display("FAIL rw_same_old got=%h exp=aaaaaaaa", instr_out);
        end
        drive(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0); cyc();
        n_cmp++; if (instr_out !== 32'h5555_5555) begin
            n_bad++; $display("FAIL rw_same_new got=%h exp=55555555", instr_out);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0); cyc();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 79)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a = $urandom;
        return a;
    endfunction

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, rnd_addr(),
                  $urandom_range(0, 2) == 0, rnd_addr(), $urandom);
            cyc();
            n_cmp++; if (instr_out !== m_instr) begin n_bad++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, instr_out, m_instr); end
            n_cmp++; if (instr_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, instr_valid, m_valid); end
            n_cmp++; if (fault_misalign !== m_mis) begin n_bad++; $display("FAIL rnd_mis i=%0d got=%b exp=%b", i, fault_misalign, m_mis); end
            n_cmp++; if (fault_range !== m_rng) begin n_bad++; $display("FAIL rnd_rng i=%0d got=%b exp=%b", i, fault_range, m_rng); end
            n_cmp++; if (init_busy !== (m_init > 0)) begin n_bad++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, init_busy, m_init > 0); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc();
    endtask

    task automatic test_reset_mid();
        int cnt;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), $urandom);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 1'b0, 32'h0, 32'h0);
            cyc();
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'hC, 1'b1, 32'h0, 32'h1234_5678);
        cyc();
        n_cmp++; if (instr_valid !== 1'b0 || init_busy !== 1'b1 || instr_out !== DEF) begin
            n_bad++; $display("FAIL mid_reset got=%h v%b b%b exp=%h v0 b1", instr_out, instr_valid, init_busy, DEF);
        end
        reset = 1'b0;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 200) begin
            drive($urandom_range(0, 1) == 1, 1'b0, 32'($urandom_range(0, 63)) << 2,
                  $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)) << 2, $urandom);
            cnt++;
            cyc();
            n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL init_valid cyc=%0d got=%b exp=0", cnt, instr_valid); end
        end
        n_cmp++; if (cnt != 64) begin n_bad++; $display("FAIL reinit_len got=%0d exp=64", cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 1'b0, 32'h0, 32'h0);
            cyc();
            n_cmp++; if (instr_out !== DEF || instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL reinit_read addr=%h got=%h v%b exp=%h v1", i * 4, instr_out, instr_valid, DEF);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc();
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_stall();
        test_faults();
        test_same_word();
        test_random(400);
        test_reset_mid();
        test_random(200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_sync_loadable.md
Name: imem_sync_loadable

Overview:
- Parametrised, synchronous instruction memory replacing the fixed combinational case-ROM in the single-cycle/pipelined LEGv8 core.
- Contents are loaded at run time through a write (programming) port, so test programs no longer need recompiling.
- After reset, every word is cleared to a default instruction, BR X11.
- Reads are word-addressed from a byte PC with one-cycle registered latency, stall hold, and alignment/range fault flags.

Parameters:
DEPTH, 64, number of 32-bit instruction words (power of two, 4..4096)
AW, $clog2(DEPTH), word-index width (derived; not overridden)
DEFAULT_INSTR, 32'hD600_0160, fill/out-of-range word (BR X11)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
rd_req  in  1  fetch request this cycle
rd_addr  in  32  byte address (PC)
rd_stall  in  1  pipeline stall; hold fetch outputs
instr_out  out  32  fetched instruction (registered)
instr_valid  out  1  instr_out corresponds to an accepted request
fault_misalign  out  1  accepted request had rd_addr[1:0] != 0
fault_range  out  1  accepted request had rd_addr[31:2] >= DEPTH
wr_en  in  1  program-load write strobe
wr_addr  in  32  byte address of word to write
wr_data  in  32  instruction word to write
init_busy  out  1  high while the clear sequence runs

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- State machine has two states: INIT and RUN.
- Reset, asserted at any time including mid-fetch or mid-load:
  - state goes to INIT; clear counter = 0.
  - init_busy = 1.
  - instr_out = DEFAULT_INSTR; instr_valid, fault_misalign, fault_range = 0.
- INIT:
  - Each cycle, mem[cnt] <= DEFAULT_INSTR and cnt increments.
  - When cnt == DEPTH-1 is written, the next state is RUN and init_busy drops to 0. INIT therefore lasts exactly DEPTH cycles after reset deasserts.
  - rd_req and wr_en are ignored. instr_valid stays 0 and the faults stay 0.
- RUN, read path:
  - A request is accepted when rd_req=1 and rd_stall=0.
  - For a request accepted at edge N, the results appear after edge N+1 (one-cycle latency):
    - idx = rd_addr[31:2].
    - instr_out = mem[idx[AW-1:0]] if idx < DEPTH, else DEFAULT_INSTR.
    - instr_valid = 1.
    - fault_range = (idx >= DEPTH).
    - fault_misalign = (rd_addr[1:0] != 0). The word is still fetched using the truncated idx.
  - rd_stall=1: instr_out, instr_valid and both faults hold their values; any rd_req is dropped.
  - rd_req=0 with rd_stall=0: instr_valid <= 0 and both faults <= 0; instr_out holds its last value.
- RUN, write path:
  - A write is performed when wr_en=1, wr_addr[1:0]==0 and wr_addr[31:2] < DEPTH: mem[wr_addr[AW+1:2]] <= wr_data at the edge.
  - Misaligned or out-of-range writes are silently dropped. No fault is reported for writes.
  - Writes are independent of rd_stall.
- Read and write to the same word in the same cycle: read-first, i.e. instr_out returns the old content. The new content is visible to a request accepted on the following cycle.
- The PC is never modified by this block. fault_* are informational only; the core decides whether to trap.
- Memory has no reset other than the INIT clear sequence. The array must map to inferred RAM: a single write port muxed between the INIT clear and wr_en, and a registered read.

Test Plan:
- Clear sequence: reset for 2 cycles, then release → init_busy=1 for exactly 64 cycles and then 0. Reading rd_addr=0x0, 0x4 and 0xFC each returns 32'hD600_0160 with instr_valid=1 and no faults.
- Load and fetch: write 0xD2800021 at 0x0, 0xD2800042 at 0x4 and 0x8B020024 at 0x8. Request 0x0, 0x4, 0x8 back-to-back → the same three words appear on consecutive cycles, each one cycle after its request, with instr_valid=1 throughout.
- Stall hold: issue a request for 0x4, then hold rd_stall=1 for 3 cycles while rd_req=1 with rd_addr=0x8 → instr_out stays 0xD2800042 with valid=1. Release the stall → 0x8B020024 arrives one cycle later.
- Faults:
  - rd_addr=0x100 (idx 64) → instr_out=0xD600_0160, fault_range=1.
  - rd_addr=0x6 → word at 0x4 is returned, fault_misalign=1.
  - wr_en to 0x102 and to 0x200 → the contents of 0x0 and 0x100 are unchanged.
- Same-word read/write: preload 0xAAAA_AAAA at 0x10. In one cycle, read 0x10 and write 0x5555_5555 to 0x10 → 0xAAAA_AAAA is returned. The next read returns 0x5555_5555.
- Reset mid-operation:
  - Assert reset during a fetch stream after loading programs → instr_valid=0 on the next cycle, and INIT reruns for 64 cycles.
  - Afterwards, all addresses read 0xD600_0160.
  - Reads and writes attempted during INIT have no effect and instr_valid stays 0.
